// File: rtl/mesh_ep_pkg.sv
// mesh_ep_pkg: header field offsets, RX state encoding and address helpers for mesh_term_endpoint.
// Offsets index the 17-bit header slice taken from the top of each packet.
package mesh_ep_pkg;
  localparam int HDR_W    = 17;
  localparam int NXT_MSB  = 16;
  localparam int ROW_MSB  = 8;
  localparam int COL_MSB  = 4;
  localparam int MODE_BIT = 0;
  typedef enum logic [1:0] {IDLE, POP, HOLD} rx_state_e;
  function automatic logic [3:0] pkt_row(input logic [HDR_W-1:0] hdr);
    return hdr[ROW_MSB -: 4];
  endfunction
  function automatic logic [3:0] pkt_col(input logic [HDR_W-1:0] hdr);
    return hdr[COL_MSB -: 4];
  endfunction
endpackage

// File: rtl/mesh_ep_fifo.sv
// mesh_ep_fifo: show-ahead FIFO; a push into a full FIFO is taken only alongside a pop.
module mesh_ep_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
endmodule

// File: rtl/mesh_term_endpoint.sv
// mesh_term_endpoint: mesh port device with a buffered TX path and a pop/hold RX path.
// MESH_EP_ADDR_CHECK_EN enables destination checking and misroute dropping on RX.
module mesh_term_endpoint
  import mesh_ep_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int ROW        = 1,
  parameter int COLUM      = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [pckg_sz-1:0] tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [pckg_sz-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               err_misroute,
  output logic [15:0]        tx_count,
  output logic [15:0]        rx_count
);
  logic               empty;
  logic               hit;
  rx_state_e          state_q;
  logic [pckg_sz-1:0] rx_data_q;
  logic               err_q;
  logic [15:0]        tx_cnt_q, rx_cnt_q;
  mesh_ep_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .push_i (tx_push),
    .data_i (tx_data),
    .pop_i  (popin),
    .full_o (tx_full),
    .empty_o(empty),
    .head_o (data_out_i_in)
  );
`ifdef MESH_EP_ADDR_CHECK_EN
  logic [HDR_W-1:0] hdr;
  assign hdr = data_out[pckg_sz-1 -: HDR_W];
  assign hit = (pkt_row(hdr) == 4'(ROW)) && (pkt_col(hdr) == 4'(COLUM));
`else
  assign hit = 1'b1;
`endif
  assign pndng_i_in   = !empty;
  assign pop          = state_q == POP;
  assign rx_valid     = state_q == HOLD;
  assign rx_data      = rx_data_q;
  assign err_misroute = err_q;
  assign tx_count     = tx_cnt_q;
  assign rx_count     = rx_cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q   <= IDLE;
      rx_data_q <= '0;
      err_q     <= 1'b0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (popin && !empty) tx_cnt_q <= tx_cnt_q + 16'd1;
      case (state_q)
        IDLE: if (pndng) state_q <= POP;
        POP: begin
          state_q <= hit ? HOLD : IDLE;
          if (hit) rx_data_q <= data_out;
          err_q <= err_q | ~hit;
        end
        HOLD: if (rx_ready) begin
          state_q  <= IDLE;
          rx_cnt_q <= rx_cnt_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule
